// File: rtl/on_chip_ram.sv
// -----------------------------------------------------------------------------
// on_chip_ram
//   Single-port synchronous RAM of 2^DEPTH_LOG2 words by WIDTH bits, with a
//   registered read port and one-cycle latency. Only the low DEPTH_LOG2 bits of
//   the address are decoded, so higher address bits alias onto the same words.
//   A write also returns the new word on oData (write-through).
//
//   Optional feature (macro ON_CHIP_RAM_CLEAR_EN):
//     When the macro is defined, every reset starts a clear sweep. The sweep
//     writes zero to each word in turn, one word per cycle, and oBusy stays high
//     until the last word has been written. Accesses are ignored while oBusy is
//     high. When the macro is undefined, oBusy is tied low. Memory contents then
//     survive reset and are undefined at power-up.
//
// Ports
//   iClock    in   1      sole clock, rising edge
//   iReset    in   1      synchronous, active-low reset
//   iAddress  in   32     word address, bits [DEPTH_LOG2-1:0] used
//   iData     in   WIDTH  write data
//   iWrite    in   1      1 = write, 0 = read (qualified by iEnable)
//   iEnable   in   1      access request
//   oData     out  WIDTH  registered read / write-through data
//   oValid    out  1      oData holds the result of the access taken last edge
//   oBusy     out  1      accesses are ignored (clear sweep in progress)
// -----------------------------------------------------------------------------
module on_chip_ram #(
    parameter int DEPTH_LOG2 = 10,
    parameter int WIDTH      = 32
) (
    input  logic             iClock,
    input  logic             iReset,
    input  logic [31:0]      iAddress,
    input  logic [WIDTH-1:0] iData,
    input  logic             iWrite,
    input  logic             iEnable,
    output logic [WIDTH-1:0] oData,
    output logic             oValid,
    output logic             oBusy
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] index;
    logic                  accept;
    logic                  memWe;
    logic [DEPTH_LOG2-1:0] memAddr;
    logic [WIDTH-1:0]      memWdata;

    // The upper address bits are ignored on purpose, which makes addresses alias.
    logic unusedAddrBits;
    assign unusedAddrBits = ^iAddress[31:DEPTH_LOG2];

    assign index  = iAddress[DEPTH_LOG2-1:0];
    assign accept = iReset && iEnable && !oBusy;

`ifdef ON_CHIP_RAM_CLEAR_EN
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } stateT;

    stateT                 state;
    stateT                 nextState;
    logic [DEPTH_LOG2-1:0] counter;
    logic                  clearWe;

    // A reset edge always sends the FSM to CLEAR at word 0. A reset that arrives
    // during a sweep therefore restarts the sweep.
    always_ff @(posedge iClock) begin
        if (!iReset) begin
            state   <= CLEAR;
            counter <= '0;
        end else begin
            state <= nextState;
            if (state == CLEAR) begin
                counter <= counter + 1'b1;
            end
        end
    end

    // NOTE: every signal written in an always_comb gets a default first, so no
    // path through the block leaves it unassigned. Otherwise a latch is inferred.
    always_comb begin
        nextState = state;
        if (state == CLEAR && counter == '1) begin
            nextState = IDLE;
        end
    end

    // oBusy drops on the same edge that writes the last word.
    always_comb begin
        oBusy   = (state == CLEAR);
        clearWe = (state == CLEAR) && iReset;
    end

    // The sweep and user writes share one write port. The two never overlap,
    // because accept is gated by oBusy.
    always_comb begin
        memWe    = clearWe || (accept && iWrite);
        memAddr  = clearWe ? counter : index;
        memWdata = clearWe ? '0 : iData;
    end
`else
    assign oBusy = 1'b0;

    always_comb begin
        memWe    = accept && iWrite;
        memAddr  = index;
        memWdata = iData;
    end
`endif

    // NOTE: the storage array has no reset branch. Resetting it would turn the
    // RAM into a flop array. Clearing, when it is wanted, is done by the sweep.
    always_ff @(posedge iClock) begin
        if (memWe) begin
            mem[memAddr] <= memWdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only. The read of
    // mem[index] therefore sees the word as it was before this edge.
    always_ff @(posedge iClock) begin
        if (!iReset) begin
            oData  <= '0;
            oValid <= 1'b0;
        end else if (accept) begin
            oData  <= iWrite ? iData : mem[index];
            oValid <= 1'b1;
        end else begin
            oValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_on_chip_ram.sv
// -----------------------------------------------------------------------------
// tb_on_chip_ram
//   Directed self-checking bench for on_chip_ram with the default parameters
//   (1024 x 32). Inputs change 1 ns after each rising edge and outputs are
//   sampled at the same point. Expected values are hand-computed constants.
//   Clear-sweep checks are compiled in when ON_CHIP_RAM_CLEAR_EN is defined.
// -----------------------------------------------------------------------------
module tb_on_chip_ram;

    logic        iClock;
    logic        iReset;
    logic [31:0] iAddress;
    logic [31:0] iData;
    logic        iWrite;
    logic        iEnable;
    logic [31:0] oData;
    logic        oValid;
    logic        oBusy;

    int checks = 0;
    int errors = 0;

    on_chip_ram dut (
        .iClock   (iClock),
        .iReset   (iReset),
        .iAddress (iAddress),
        .iData    (iData),
        .iWrite   (iWrite),
        .iEnable  (iEnable),
        .oData    (oData),
        .oValid   (oValid),
        .oBusy    (oBusy)
    );

    initial iClock = 1'b0;
    always #5 iClock = ~iClock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Present one set of inputs for exactly one rising edge, then sample.
    task automatic cycle(input logic rst, input logic en, input logic wr,
                         input logic [31:0] addr, input logic [31:0] data);
        iReset   = rst;
        iEnable  = en;
        iWrite   = wr;
        iAddress = addr;
        iData    = data;
        @(posedge iClock);
        #1;
    endtask

    task automatic doWrite(input logic [31:0] addr, input logic [31:0] data);
        cycle(1'b1, 1'b1, 1'b1, addr, data);
    endtask

    task automatic doRead(input logic [31:0] addr);
        cycle(1'b1, 1'b1, 1'b0, addr, 32'h0);
    endtask

    task automatic doIdle();
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

`ifdef ON_CHIP_RAM_CLEAR_EN
    // Release reset and count the edges until oBusy falls. If probeAt is not
    // negative, a read is presented on that sweep cycle and must be ignored.
    task automatic waitSweep(input string tag, input int probeAt, input int expectCycles);
        int busyCycles = 0;
        while (oBusy === 1'b1 && busyCycles < 2000) begin
            if (busyCycles == probeAt) begin
                doRead(32'h3);
                check({tag, "_probe_valid"}, {31'b0, oValid}, 32'h0);
            end else begin
                doIdle();
            end
            busyCycles++;
        end
        check({tag, "_cycles"}, busyCycles, expectCycles);
    endtask
`endif

    initial begin
        iReset   = 1'b0;
        iEnable  = 1'b0;
        iWrite   = 1'b0;
        iAddress = 32'h0;
        iData    = 32'h0;

        // Reset state.
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        cycle(1'b0, 1'b1, 1'b1, 32'h1, 32'h1);
        check("reset_odata", oData, 32'h0);
        check("reset_ovalid", {31'b0, oValid}, 32'h0);
`ifdef ON_CHIP_RAM_CLEAR_EN
        check("reset_obusy", {31'b0, oBusy}, 32'h1);
        waitSweep("sweep1", 10, 1024);
`else
        check("reset_obusy", {31'b0, oBusy}, 32'h0);
`endif
        doIdle();
        check("idle_after_reset_obusy", {31'b0, oBusy}, 32'h0);
        check("idle_after_reset_ovalid", {31'b0, oValid}, 32'h0);

        // Write-through, then read the same word and its alias.
        doWrite(32'h400, 32'hDEADBEEF);
        check("wr400_valid", {31'b0, oValid}, 32'h1);
        check("wr400_data", oData, 32'hDEADBEEF);
        doRead(32'h400);
        check("rd400_valid", {31'b0, oValid}, 32'h1);
        check("rd400_data", oData, 32'hDEADBEEF);
        doRead(32'h000);
        check("rd000_alias", oData, 32'hDEADBEEF);

        // Aliasing through a higher address.
        doWrite(32'h005, 32'h12345678);
        doRead(32'h405);
        check("rd405_alias", oData, 32'h12345678);

        // A disabled write leaves memory unchanged, drops oValid and holds oData.
        doWrite(32'h007, 32'h11111111);
        cycle(1'b1, 1'b0, 1'b1, 32'h007, 32'hFFFFFFFF);
        check("disabled_valid", {31'b0, oValid}, 32'h0);
        check("disabled_hold", oData, 32'h11111111);
        doRead(32'h007);
        check("rd7_unchanged", oData, 32'h11111111);

        // Back-to-back: read after write to the same index, writes and reads on
        // consecutive cycles, and reads of different words.
        doWrite(32'h008, 32'hCAFEF00D);
        doRead(32'h008);
        check("b2b_rd8", oData, 32'hCAFEF00D);
        doWrite(32'h009, 32'h00000009);
        doWrite(32'h00A, 32'h0000000A);
        doRead(32'h009);
        check("b2b_rd9", oData, 32'h00000009);
        doRead(32'h00A);
        check("b2b_rd10_valid", {31'b0, oValid}, 32'h1);
        check("b2b_rd10", oData, 32'h0000000A);
        doWrite(32'h008, 32'h88888888);
        doRead(32'h008);
        check("b2b_rd8_new", oData, 32'h88888888);

        // An idle cycle holds oData and drops oValid.
        doIdle();
        check("idle_valid", {31'b0, oValid}, 32'h0);
        check("idle_hold", oData, 32'h88888888);

        // The top index, reached through an all-ones address.
        doWrite(32'h3FF, 32'h0BADC0DE);
        doRead(32'hFFFFFFFF);
        check("rd_top", oData, 32'h0BADC0DE);
        doRead(32'h000);
        check("rd_bottom", oData, 32'hDEADBEEF);

        // Reset during a write aborts the write.
        doWrite(32'h003, 32'hA5A5A5A5);
        check("wr3_data", oData, 32'hA5A5A5A5);
        cycle(1'b0, 1'b1, 1'b1, 32'h003, 32'h5A5A5A5A);
        check("rst_mid_odata", oData, 32'h0);
        check("rst_mid_ovalid", {31'b0, oValid}, 32'h0);
`ifdef ON_CHIP_RAM_CLEAR_EN
        waitSweep("sweep2", -1, 1024);
        doRead(32'h003);
        check("cleared_rd3", oData, 32'h0);
        doRead(32'h3FF);
        check("cleared_rd1023", oData, 32'h0);

        // Reset at sweep cycle 500 restarts the sweep from index 0.
        doWrite(32'h010, 32'h77777777);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 500; i++) begin
            doIdle();
        end
        check("restart_busy_mid", {31'b0, oBusy}, 32'h1);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        waitSweep("sweep3", -1, 1024);
        doRead(32'h010);
        check("restart_rd16", oData, 32'h0);
`else
        doIdle();
        check("rst_obusy", {31'b0, oBusy}, 32'h0);
        doRead(32'h003);
        check("preserved_rd3", oData, 32'hA5A5A5A5);
        doRead(32'h3FF);
        check("preserved_rd1023", oData, 32'h0BADC0DE);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/on_chip_ram.md
ON_CHIP_RAM -- requirements
Module: on_chip_ram

Interface
REQ-001 Parameter DEPTH_LOG2, default 10, log2 of word count (1024 x 32-bit words).
REQ-002 Parameter WIDTH, default 32, data word width in bits.
REQ-003 iClock  input  1  sole clock; all state updates on rising edge.
REQ-004 iReset  input  1  reset, synchronous, active-low.
REQ-005 iAddress  input  32  word address; only bits [DEPTH_LOG2-1:0] used.
REQ-006 iData  input  WIDTH  write data.
REQ-007 iWrite  input  1  1 = write, 0 = read (qualified by iEnable).
REQ-008 iEnable  input  1  access request; when 0, no access occurs.
REQ-009 oData  output  WIDTH  registered read data.
REQ-010 oValid  output  1  one-cycle strobe: oData carries the result of the access accepted on the previous edge.
REQ-011 oBusy  output  1  1 = accesses ignored (reset or clear sweep).

Function
REQ-012 Storage SHALL be 2^DEPTH_LOG2 words x WIDTH bits; index = iAddress[DEPTH_LOG2-1:0]; higher address bits SHALL be ignored (aliasing; e.g. 0x400 and 0x000 hit index 0).
REQ-013 Access accepted on an edge iff iReset=1, iEnable=1, oBusy=0.
REQ-014 Accepted write: mem[index] <= iData; oData <= iData (write-through / new data); oValid <= 1.
REQ-015 Accepted read: oData <= mem[index] as of before the edge; oValid <= 1; read latency exactly 1 cycle.
REQ-016 No accepted access: oData SHALL hold its value; oValid <= 0.
REQ-017 Back-to-back accesses SHALL be accepted every cycle; read following a write to the same index SHALL return the new data.
REQ-018 iWrite and iData SHALL be ignored when iEnable=0; memory SHALL not change.
REQ-019 Out-of-range concept does not exist: every index 0..2^DEPTH_LOG2-1 SHALL be valid, with no wrap side effects beyond REQ-012.

Reset
REQ-020 While iReset=0 at an edge: oData <= 0, oValid <= 0; any access that cycle SHALL be ignored.
REQ-021 Without ON_CHIP_RAM_CLEAR_EN: oBusy SHALL be 0 after reset; memory contents SHALL be preserved across reset (undefined at power-up).
REQ-022 Reset asserted mid-operation SHALL abort it; no partial write of the presented word occurs on a reset edge.

Configuration
REQ-023 Macro ON_CHIP_RAM_CLEAR_EN, when defined, SHALL add a clear sweep: two states IDLE and CLEAR with a DEPTH_LOG2-bit counter.
REQ-024 With the macro: iReset=0 edge -> state CLEAR, counter 0, oBusy 1; each edge in CLEAR with iReset=1 writes 0 to mem[counter] and increments counter.
REQ-025 With the macro: after writing index 2^DEPTH_LOG2-1 the state SHALL go to IDLE and oBusy SHALL fall on that same edge; sweep takes exactly 2^DEPTH_LOG2 cycles after reset release.
REQ-026 With the macro: reset during CLEAR SHALL restart the sweep from index 0; accesses during CLEAR SHALL be ignored (oValid stays 0).
REQ-027 Without the macro: no sweep logic; oBusy tied 0; state behaviour per REQ-021.

Verification
REQ-028 Write 0xDEADBEEF to address 0x400, read 0x400 next cycle -> oValid=1 and oData=0xDEADBEEF one cycle after the read.
REQ-029 Write 0x12345678 at 0x005, read address 0x405 -> oData=0x12345678 (aliasing).
REQ-030 iEnable=0, iWrite=1, iData=0xFFFFFFFF at index 7, then read index 7 -> prior contents unchanged, oValid=0 during the disabled cycle.
REQ-031 Write 0xA5A5A5A5 to index 3, then assert iReset=0 for one cycle -> oData=0, oValid=0; without the macro, a read of index 3 returns 0xA5A5A5A5.
REQ-032 With ON_CHIP_RAM_CLEAR_EN: after reset release, oBusy=1 for exactly 1024 cycles; a read at cycle 10 is ignored; after oBusy falls, reading index 3 and 1023 returns 0.
REQ-033 With the macro: assert reset at sweep cycle 500 -> sweep restarts, oBusy stays 1 for 1024 cycles after the second release.
